// File: rtl/spi_read_capture_pkg.sv
// Shared constants and FSM state type for the SPI read-capture snooper.
// Command opcodes, phase widths and the framing state enum live here.
package spi_pkg;

    localparam logic [7:0] CMD_WR_REG = 8'h01;
    localparam logic [7:0] CMD_RD_REG = 8'h07;
    localparam logic [7:0] CMD_RD_MEM = 8'h0B;

    localparam int CMD_BITS  = 8;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;
    localparam int WREG_BITS = 8;

    // Wide enough for the longest phase, including long dummy runs.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA
    } state_t;

endpackage

// File: rtl/spi_read_capture_if.sv
// Snooped SPI lines, fetch request and capture-FIFO readout of spi_read_capture.
// The slave modport is the capture block's view; master is the stimulus side.
interface spi_read_capture_if
    import spi_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 spi_sclk_i;
    logic                 spi_cs_i;
    logic                 spi_sdo_i;
    logic                 spi_sdi_i;
    logic                 fetch_i;
    logic [DATA_BITS-1:0] rdata_o;
    logic [ADDR_BITS-1:0] raddr_o;
    logic                 rvalid_o;
    logic [CW-1:0]        count_o;
    logic                 overflow_o;
    logic                 proto_err_o;

    modport master (
        output spi_sclk_i, spi_cs_i, spi_sdo_i, spi_sdi_i, fetch_i,
        input  rdata_o, raddr_o, rvalid_o, count_o, overflow_o, proto_err_o
    );

    modport slave (
        input  spi_sclk_i, spi_cs_i, spi_sdo_i, spi_sdi_i, fetch_i,
        output rdata_o, raddr_o, rvalid_o, count_o, overflow_o, proto_err_o
    );

endinterface

// File: rtl/spi_read_capture_fifo.sv
// Synchronous capture FIFO with occupancy count; pushes into a full FIFO are
// dropped (flagged on o_drop) unless a pop frees the slot in the same cycle.
module capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_do_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_read_capture.sv
// Passive SPI snooper: frames master commands and captures read-response words
// into a FIFO. Define SPI_CAPTURE_ADDR_EN to tag each entry with its address.
module spi_read_capture
    import spi_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DUMMY_MEM = 34,
    parameter int DUMMY_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    spi_read_capture_if.slave bus
);
`ifdef SPI_CAPTURE_ADDR_EN
    localparam int FW = ADDR_BITS + DATA_BITS;
`else
    localparam int FW = DATA_BITS;
`endif
    localparam int CW = $clog2(DEPTH) + 1;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sclk_q, r_armed, r_rd, r_push, r_proto_err, r_overflow;
    logic [CMD_BITS-2:0]  r_cmd;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_data;

    logic                 w_rise, w_last, w_frame_start, w_drop, w_empty, w_full_unused;
    logic [CMD_BITS-1:0]  w_cmd;
    logic [FW-1:0]        w_wdata, w_head;
    logic [CW-1:0]        w_count;

    assign w_rise        = bus.spi_sclk_i & ~r_sclk_q;
    assign w_last        = (r_cnt == '0);
    assign w_frame_start = (r_state == CMD) && (r_cnt == CNT_W'(CMD_BITS - 1));
    assign w_cmd         = {r_cmd, bus.spi_sdo_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sclk_q    <= 1'b0;
            r_armed     <= 1'b0;
            r_rd        <= 1'b0;
            r_push      <= 1'b0;
            r_proto_err <= 1'b0;
            r_overflow  <= 1'b0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_sclk_q <= bus.spi_sclk_i;
            r_push   <= 1'b0;
            if (w_drop) r_overflow <= 1'b1;
            if (bus.spi_cs_i) r_armed <= 1'b1;

            // CS high is only legal between frames; anywhere else the word is abandoned.
            if (bus.spi_cs_i) begin
                if (r_state != IDLE && !w_frame_start) r_proto_err <= 1'b1;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: if (r_armed) begin
                        r_state <= CMD;
                        r_cnt   <= CNT_W'(CMD_BITS - 1);
                    end
                    CMD: if (w_rise) begin
                        r_cmd <= w_cmd[CMD_BITS-2:0];
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) begin
                            r_rd    <= (w_cmd == CMD_RD_MEM);
                            r_state <= ADDR;
                            r_cnt   <= CNT_W'(ADDR_BITS - 1);
                            if (w_cmd == CMD_WR_REG) begin
                                r_state <= WDATA;
                                r_cnt   <= CNT_W'(WREG_BITS - 1);
                            end else if (w_cmd == CMD_RD_REG) begin
                                r_addr  <= '0;
                                r_state <= (DUMMY_REG == 0) ? RDATA : DUMMY;
                                r_cnt   <= (DUMMY_REG == 0) ? CNT_W'(DATA_BITS - 1) : CNT_W'(DUMMY_REG - 1);
                            end
                        end
                    end
                    ADDR: if (w_rise) begin
                        r_addr <= {r_addr[ADDR_BITS-2:0], bus.spi_sdo_i};
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (w_last) begin
                            if (r_rd) begin
                                r_state <= (DUMMY_MEM == 0) ? RDATA : DUMMY;
                                r_cnt   <= (DUMMY_MEM == 0) ? CNT_W'(DATA_BITS - 1) : CNT_W'(DUMMY_MEM - 1);
                            end else begin
                                r_state <= WDATA;
                                r_cnt   <= CNT_W'(DATA_BITS - 1);
                            end
                        end
                    end
                    DUMMY: if (w_rise) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) begin
                            r_state <= RDATA;
                            r_cnt   <= CNT_W'(DATA_BITS - 1);
                        end
                    end
                    RDATA: if (w_rise) begin
                        r_data <= {r_data[DATA_BITS-2:0], bus.spi_sdi_i};
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (w_last) begin
                            r_push  <= 1'b1;
                            r_state <= CMD;
                            r_cnt   <= CNT_W'(CMD_BITS - 1);
                        end
                    end
                    WDATA: if (w_rise) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) begin
                            r_state <= CMD;
                            r_cnt   <= CNT_W'(CMD_BITS - 1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_CAPTURE_ADDR_EN
    assign w_wdata     = {r_addr, r_data};
    assign bus.raddr_o = w_head[FW-1:DATA_BITS];
`else
    // Address is still shifted so framing stays aligned, but nothing is stored.
    logic w_addr_unused;
    assign w_addr_unused = ^r_addr;
    assign w_wdata       = r_data;
    assign bus.raddr_o   = '0;
`endif

    capture_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (r_push),
        .i_data  (w_wdata),
        .i_pop   (bus.fetch_i),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full_unused),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    assign bus.rdata_o     = w_head[DATA_BITS-1:0];
    assign bus.rvalid_o    = ~w_empty;
    assign bus.count_o     = w_count;
    assign bus.overflow_o  = r_overflow;
    assign bus.proto_err_o = r_proto_err;

endmodule

// File: doc/spi_read_capture.md
# spi_read_capture

Snoop-and-capture stage downstream of the SPI stimulus master on the FPGA test bench. It watches the master's SPI outputs and the DUT's serial data return line, tracks command framing across back-to-back transactions, and shifts in read-response words. Captured words go into a small FIFO that the operator drains one word per fetch pulse for LED/debug readout. The block runs in the master's clock domain and has no influence on the SPI bus.

## Interface
- DEPTH, 8: capture FIFO entries (power of 2, ≥2).
- DUMMY_MEM, 34: dummy SCLK cycles between address and data for read-mem.
- DUMMY_REG, 1: dummy SCLK cycles between command and data for read-reg.
- clk_i  in  1  bench clock; SCLK toggles at most once per clk_i.
- rst_i  in  1  reset; asynchronous, active-high.
- spi_sclk_i  in  1  SCLK from master (clk_i-synchronous).
- spi_cs_i  in  1  chip select from master, active-low.
- spi_sdo_i  in  1  master→DUT data (clk_i-synchronous).
- spi_sdi_i  in  1  DUT→master data.
- fetch_i  in  1  single-cycle pop request.
- rdata_o  out  32  FIFO head word (captured data).
- raddr_o  out  32  FIFO head address tag (only with SPI_CAPTURE_ADDR_EN; otherwise tied 0).
- rvalid_o  out  1  FIFO non-empty.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: a word was dropped because the FIFO was full.
- proto_err_o  out  1  sticky: CS rose mid-frame.

## Operation
- Rising SCLK edge detected as spi_sclk_i=1 and registered sclk_q=0; spi_sdo_i and spi_sdi_i are sampled in that cycle. No activity while spi_cs_i=1.
- Bits are MSB-first; a bit counter reloads at each phase entry.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA.
  - IDLE → CMD when spi_cs_i=0 (first rising edge is cmd bit 7).
  - CMD (8 bits), after bit 0: 0x07 → DUMMY (DUMMY_REG); 0x01 → WDATA (8 bits); 0x0B → ADDR (read); any other → ADDR (write).
  - ADDR (32 bits, shifted into addr register), after bit 0: read → DUMMY (DUMMY_MEM); write → WDATA (32 bits).
  - DUMMY: counts the configured number of edges → RDATA (32 bits). With 0 dummy cycles, DUMMY is skipped.
  - RDATA: shifts spi_sdi_i; after bit 0, pushes {addr, data} (addr=0 for 0x07) → CMD.
  - WDATA: ignores data; after bit 0 → CMD.
- CS stays low between transactions; the next frame starts on the next edge in CMD.
- spi_cs_i=1 in any state other than IDLE or CMD-with-0-bits: go to IDLE, set proto_err_o, discard the partial word.
- FIFO: push on RDATA completion; pop when fetch_i=1 and rvalid_o=1.
  - Pop when empty: ignored.
  - Push when full: word dropped, overflow_o set.
  - Simultaneous push and pop when full: both succeed, count unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Sticky flags clear only on rst_i.

## Timing
- Reset values: state IDLE; all FIFO pointers and count 0; rdata_o=0, raddr_o=0, rvalid_o=0, count_o=0, overflow_o=0, proto_err_o=0; sclk_q=0.
- Latency: the push happens in the clk_i cycle after the last RDATA bit is sampled. rvalid_o and count_o update one cycle after the push.
- rdata_o/raddr_o come from the registered FIFO head; they are valid whenever rvalid_o=1 and advance the cycle after a pop.
- rst_i asserted mid-frame clears everything immediately. After release the block waits for CS high before arming (IDLE requires one cycle with spi_cs_i=1 first).

## Configuration
- SPI_CAPTURE_ADDR_EN defined: the FIFO stores a 32-bit address tag per entry and raddr_o reflects the head tag.
- SPI_CAPTURE_ADDR_EN undefined: no tag storage; raddr_o is constant 0; the ADDR-phase shift register is still present for framing only.

## Structure
- Shared package spi_pkg holds:
  - Command constants: CMD_WR_REG=8'h01, CMD_RD_REG=8'h07, CMD_RD_MEM=8'h0B.
  - State enum: IDLE..WDATA.
  - Phase widths: CMD_BITS=8, ADDR_BITS=32, DATA_BITS=32, WREG_BITS=8.
- One sub-module, capture_fifo: synchronous FIFO parameterised on width and depth, with full/empty/count and drop-on-full.

## Test plan
- Read-mem 0x0B, addr 0x0000_0010, 34 dummy cycles, DUT returns 0xDEADBEEF → count_o=1, rdata_o=0xDEADBEEF, raddr_o=0x10 (with macro).
- Back-to-back write-reg 0x01 data 0xA5, then read-reg 0x07 returning 0x12345678, CS held low → exactly one entry, 0x12345678, raddr_o=0.
- Write-mem 0x02, addr 0x20, data 0xFFFFFFFF, followed by read-mem returning 0x1 → one entry, value 0x1; the write data is never captured.
- DEPTH+1 read-mem transactions with no fetch → count_o=DEPTH, overflow_o=1. Draining with DEPTH fetch pulses returns the first DEPTH words in order, then rvalid_o=0.
- CS raised after 12 RDATA bits → proto_err_o=1, no push. The next full read captures correctly.
- rst_i pulsed during the ADDR phase → all outputs return to their reset values. The following transaction, after a CS-high cycle, decodes correctly.
